// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests,
// absorbs responses that land during a stall, and applies ID-resolved redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] hold_instr;

  logic        redir;
  logic [31:0] redir_target;
  logic [31:0] pc_plus4;

  // Valid/ready: imem_req is a one-cycle pulse carrying imem_addr; exactly one
  // imem_rvalid beat answers it, and only a beat seen in S_WAIT is consumed.
  assign redir        = (jump | branch_taken) & ~stall;
  assign redir_target = jump ? jump_target : branch_target;
  assign pc_plus4     = pc + 32'd4;

  assign imem_req  = rst & (state == S_REQ) & ~redir;
  assign imem_addr = pc;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      hold_instr  <= 32'h0;
      if_id_pc    <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_instr <= 32'h0;
      if_id_valid <= 1'b0;
    end else begin
      // Bubble by default when not stalled; a load below overrides it.
      if (!stall) if_id_valid <= 1'b0;

      case (state)
        S_REQ: begin
          if (redir) pc <= redir_target;
          else       state <= S_WAIT;
        end

        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill || redir) begin
              kill  <= 1'b0;
              state <= S_REQ;
              if (redir) pc <= redir_target;
            end else if (stall) begin
              hold_instr <= imem_rdata;
              state      <= S_HOLD;
            end else begin
              if_id_pc    <= pc;
              if_id_pc4   <= pc_plus4;
              if_id_instr <= imem_rdata;
              if_id_valid <= 1'b1;
              pc          <= pc_plus4;
              state       <= S_REQ;
            end
          end else if (redir) begin
            // Response still owed for the old PC; mark it to be discarded.
            kill <= 1'b1;
            pc   <= redir_target;
          end
        end

        S_HOLD: begin
          if (!stall) begin
            if (redir) begin
              pc <= redir_target;
            end else begin
              if_id_pc    <= pc;
              if_id_pc4   <= pc_plus4;
              if_id_instr <= hold_instr;
              if_id_valid <= 1'b1;
              pc          <= pc_plus4;
            end
            state <= S_REQ;
          end
        end

        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch cadence, stall hold buffer, redirects,
// PC wrap and asynchronous reset mid-fetch.
module tb_if_stage;

  localparam logic [31:0] RPC  = 32'h0040_0000;
  localparam logic [31:0] MASK = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;

  // memory model state
  int          lat = 1;
  int          cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;
  int          req_cnt = 0;

  if_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Memory: capture request at posedge, answer `lat` edges later with addr^MASK.
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (imem_req) begin
        pend    = 1'b1;
        paddr   = imem_addr;
        cnt     = lat;
        req_cnt = req_cnt + 1;
      end
    end else begin
      imem_rvalid = 1'b0;
      if (!rst) begin
        pend    = 1'b0;
        req_cnt = 0;
      end else if (pend) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = paddr ^ MASK;
          pend        = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== RPC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RPC); end
    checks++; if ({if_id_pc, if_id_pc4, if_id_instr} !== 96'h0) begin failures++; $display("FAIL reset_ifid got=%h/%h/%h exp=0", if_id_pc, if_id_pc4, if_id_instr); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", imem_req); end
  endtask

  task automatic test_fetch();
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      a = RPC + 32'(4 * k);
      checks++; if (imem_req !== 1'b1 || imem_addr !== a) begin failures++; $display("FAIL fetch_req%0d got=%b/%h exp=1/%h", k, imem_req, imem_addr, a); end
      @(negedge clk); #1;
      checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin failures++; $display("FAIL fetch_gap%0d got req=%b valid=%b exp=0/0", k, imem_req, if_id_valid); end
      @(negedge clk); #1;
      checks++; if (if_id_valid !== 1'b1 || if_id_pc !== a) begin failures++; $display("FAIL fetch_pc%0d got=%b/%h exp=1/%h", k, if_id_valid, if_id_pc, a); end
      checks++; if (if_id_pc4 !== a + 32'd4 || if_id_instr !== (a ^ MASK)) begin failures++; $display("FAIL fetch_data%0d got=%h/%h exp=%h/%h", k, if_id_pc4, if_id_instr, a + 32'd4, a ^ MASK); end
    end
    checks++; if (req_cnt !== 3) begin failures++; $display("FAIL fetch_reqcnt got=%0d exp=3", req_cnt); end
  endtask

  task automatic test_stall_hold();
    // req for 0x40000C is active now
    @(negedge clk);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (fsm_state !== 2'd2 || imem_req !== 1'b0) begin failures++; $display("FAIL stall_hold%0d got state=%0d req=%b exp=2/0", k, fsm_state, imem_req); end
      checks++; if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0040_0008) begin failures++; $display("FAIL stall_ifid%0d got=%b/%h exp=0/00400008", k, if_id_valid, if_id_pc); end
    end
    stall = 1'b0;
    @(negedge clk); #1;
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0040_000C || if_id_instr !== 32'hA5E5_A5A9) begin failures++; $display("FAIL stall_release got=%b/%h/%h exp=1/0040000c/a5e5a5a9", if_id_valid, if_id_pc, if_id_instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0010 || req_cnt !== 4) begin failures++; $display("FAIL stall_norereq got=%b/%h/%0d exp=1/00400010/4", imem_req, imem_addr, req_cnt); end
  endtask

  task automatic test_jump_kill();
    lat = 3;
    @(negedge clk);
    jump = 1'b1; jump_target = 32'h0000_1000;
    @(negedge clk);
    jump = 1'b0; #1;
    checks++; if (imem_addr !== 32'h0000_1000 || imem_req !== 1'b0 || fsm_state !== 2'd1) begin failures++; $display("FAIL jump_wait got=%h/%b/%0d exp=00001000/0/1", imem_addr, imem_req, fsm_state); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL jump_bubble got=%b exp=0", if_id_valid); end
    lat = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_1000) begin failures++; $display("FAIL jump_drop got valid=%b req=%b addr=%h exp=0/1/00001000", if_id_valid, imem_req, imem_addr); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0000_1000 || if_id_instr !== 32'hA5A5_B5A5) begin failures++; $display("FAIL jump_fetch got=%b/%h/%h exp=1/00001000/a5a5b5a5", if_id_valid, if_id_pc, if_id_instr); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; jump = 1'b1; branch_taken = 1'b1;
    jump_target = 32'h0000_2000; branch_target = 32'h0000_3000;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1004) begin failures++; $display("FAIL sr_noredir got=%b/%h exp=1/00001004", imem_req, imem_addr); end
    @(negedge clk); #1;
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0000_1000 || imem_addr !== 32'h0000_1004) begin failures++; $display("FAIL sr_hold1 got=%b/%h/%h exp=1/00001000/00001004", if_id_valid, if_id_pc, imem_addr); end
    @(negedge clk);
    stall = 1'b0; #1;
    checks++; if (fsm_state !== 2'd2 || if_id_valid !== 1'b1 || imem_addr !== 32'h0000_1004) begin failures++; $display("FAIL sr_hold2 got=%0d/%b/%h exp=2/1/00001004", fsm_state, if_id_valid, imem_addr); end
    @(negedge clk);
    jump = 1'b0; branch_taken = 1'b0; #1;
    checks++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_2000) begin failures++; $display("FAIL sr_redir got=%b/%b/%h exp=0/1/00002000", if_id_valid, imem_req, imem_addr); end
    checks++; if (req_cnt !== 7) begin failures++; $display("FAIL sr_reqcnt got=%0d exp=7", req_cnt); end
  endtask

  task automatic test_wrap();
    #1 jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wrap_redir_req got=%b exp=0", imem_req); end
    @(negedge clk);
    jump = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || req_cnt !== 7) begin failures++; $display("FAIL wrap_req got=%b/%h/%0d exp=1/fffffffc/7", imem_req, imem_addr, req_cnt); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hFFFF_FFFC || if_id_pc4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%b/%h/%h exp=1/fffffffc/0", if_id_valid, if_id_pc, if_id_pc4); end
    checks++; if (if_id_instr !== 32'h5A5A_5A59 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next got=%h/%b/%h exp=5a5a5a59/1/0", if_id_instr, imem_req, imem_addr); end
  endtask

  task automatic test_async_reset();
    lat = 3;
    @(negedge clk); #1;
    checks++; if (fsm_state !== 2'd1) begin failures++; $display("FAIL ar_wait got=%0d exp=1", fsm_state); end
    #2 rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || {if_id_pc, if_id_pc4, if_id_instr} !== 96'h0) begin failures++; $display("FAIL ar_zero got req=%b valid=%b pc=%h pc4=%h instr=%h exp=0", imem_req, if_id_valid, if_id_pc, if_id_pc4, if_id_instr); end
    checks++; if (imem_addr !== RPC || fsm_state !== 2'd0) begin failures++; $display("FAIL ar_pc got=%h/%0d exp=%h/0", imem_addr, fsm_state, RPC); end
    lat = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin failures++; $display("FAIL ar_firstreq got=%b/%h exp=1/%h", imem_req, imem_addr, RPC); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (if_id_valid !== 1'b1 || if_id_pc !== RPC || if_id_instr !== (RPC ^ MASK)) begin failures++; $display("FAIL ar_fetch got=%b/%h/%h exp=1/%h/%h", if_id_valid, if_id_pc, if_id_instr, RPC, RPC ^ MASK); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall_hold();
    test_jump_kill();
    test_stall_redirect();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues single-outstanding instruction-memory requests, and drives the IF/ID pipeline register consumed by the decode stage and the hazard unit. It obeys the hazard unit's `stall`, absorbs a memory response that arrives during a stall in a one-entry hold buffer, and applies branch/jump redirects resolved in ID by flushing IF/ID and discarding any in-flight fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `stall`  in  1  from hazard unit; 1 = hold PC and IF/ID
- `branch_taken`  in  1  ID-stage branch resolved taken
- `branch_target`  in  32  branch destination
- `jump`  in  1  ID-stage jump
- `jump_target`  in  32  jump destination
- `imem_req`  out  1  one-cycle fetch request pulse
- `imem_addr`  out  32  fetch address (= PC)
- `imem_rvalid`  in  1  response valid, at least 1 cycle after `imem_req`
- `imem_rdata`  in  32  instruction word
- `if_id_pc`  out  32  PC of instruction in IF/ID
- `if_id_pc4`  out  32  `if_id_pc` + 4
- `if_id_instr`  out  32  instruction in IF/ID
- `if_id_valid`  out  1  0 = bubble

## Operation
- Registers: `pc`, `state` in {S_REQ, S_WAIT, S_HOLD}, `kill`, `hold_instr`, IF/ID fields.
- Redirect accepted (`redir`) = (`jump` | `branch_taken`) & ~`stall`; target = `jump_target` if `jump`, else `branch_target` (jump wins). Redirects while `stall`=1 are ignored; ID keeps them asserted until the stall clears.
- On every `redir`: `pc` <= target, `if_id_valid` <= 0.
- S_REQ: `imem_req` = ~`redir`, `imem_addr` = `pc`. No redir -> S_WAIT. Redir -> stay in S_REQ with the new `pc`; no request issued.
- S_WAIT: `imem_req` = 0.
  - No `imem_rvalid`, redir -> `kill` <= 1, stay.
  - `imem_rvalid` & (`kill` | redir) -> drop data, `kill` <= 0, S_REQ.
  - `imem_rvalid` & `stall` -> `hold_instr` <= `imem_rdata`, S_HOLD.
  - `imem_rvalid` otherwise -> IF/ID <= {`pc`, `pc`+4, `imem_rdata`, 1}, `pc` <= `pc`+4, S_REQ.
- S_HOLD: `stall` -> hold. Redir -> drop buffer, S_REQ. Otherwise -> IF/ID <= {`pc`, `pc`+4, `hold_instr`, 1}, `pc` <= `pc`+4, S_REQ.
- IF/ID update rules:
  - `stall`=1 -> all IF/ID fields hold.
  - `stall`=0 and no load this cycle -> `if_id_valid` <= 0; other fields hold.
- Arithmetic: `pc`+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. No alignment check.

## Timing
- Reset (async, `rst`=0): `pc`=RESET_PC, state=S_REQ, `kill`=0, `hold_instr`=0, all `if_id_*`=0. `imem_req` is forced 0 while `rst`=0.
- First `imem_req` is in the first cycle after `rst` rises.
- Zero-wait memory (`imem_rvalid` one cycle after request): request at cycle t, IF/ID valid after edge t+2, next request at t+2. Throughput is 1 instruction per 2 cycles.
- At most one outstanding request. `imem_rvalid` outside S_WAIT is a protocol error and is ignored.
- Redirect-to-request latency: redir at cycle t, request for target at t+1 if not in S_WAIT. If in S_WAIT, the request follows the killed response.
- Reset mid-fetch: the outstanding response is ignored, because state=S_REQ after reset. The bench must not return stale `imem_rvalid`.

## Test plan
- Reset, RESET_PC=32'h0040_0000, zero-wait memory returning addr^32'hA5A5_A5A5 -> requests to 0x400000, 0x400004, 0x400008. IF/ID shows pc/pc4/instr matched, with valid toggling 1-0 per the 2-cycle rate.
- `stall` held 3 cycles while a response arrives in S_WAIT -> S_HOLD entered, IF/ID unchanged. Buffered instr enters IF/ID the cycle after `stall` drops. No re-request of the same `pc`.
- `jump`=1, `jump_target`=0x1000 while 3-cycle-latency fetch is outstanding -> `if_id_valid`=0 next cycle, late response dropped, next `imem_addr`=0x1000.
- `branch_taken` and `jump` together with `stall`=1 for 2 cycles, then `stall`=0 -> no redirect during stall. Redirect to `jump_target` on the first unstalled cycle.
- `pc`=32'hFFFF_FFFC fetch completes -> `if_id_pc4`=0, next `imem_addr`=0.
- Assert `rst`=0 asynchronously mid-S_WAIT -> all outputs 0 immediately. The first post-reset request is to RESET_PC.
